// File: rtl/pkt_checker_if.sv
// Decoder-side and consumer-side handshake bundle for pkt_checker.
// slave = the checker, master = decoder/consumer environment.
interface pkt_checker_if #(
    parameter int N_PKT = 48
);
    logic [N_PKT-1:0] data_DEC;
    logic             avail_DEC;
    logic             error_DEC;
    logic             read_DEC;
    logic             pkt_valid;
    logic [2:0]       pkt_type;
    logic [31:0]      pkt_data;
    logic             pkt_read;
    logic [15:0]      bad_count;

    modport slave (
        input  data_DEC, avail_DEC, error_DEC, pkt_read,
        output read_DEC, pkt_valid, pkt_type, pkt_data, bad_count
    );

    modport master (
        output data_DEC, avail_DEC, error_DEC, pkt_read,
        input  read_DEC, pkt_valid, pkt_type, pkt_data, bad_count
    );
endinterface

// File: rtl/pkt_checker.sv
// Classifies OPPM decoder packets, checks CRC-8 on data packets, queues results in a 2-deep FIFO.
// Optional macro PKT_CHECK_DROP_BAD_EN: bad packets are counted but not queued.
module pkt_checker #(
    parameter int N_PKT = 48
) (
    input  logic          clk,
    input  logic          rst_n,
    pkt_checker_if.slave  bus
);
    typedef enum logic [2:0] {
        T_DATA_OK  = 3'd0,
        T_DATA_BAD = 3'd1,
        T_READY    = 3'd2,
        T_ACK      = 3'd3,
        T_NAK      = 3'd4,
        T_UNKNOWN  = 3'd5,
        T_DEC_ERR  = 3'd6
    } pkt_type_e;

    typedef enum logic [1:0] {IDLE, CALC, PUSH} state_e;

    typedef struct packed {
        pkt_type_e   ptype;
        logic [31:0] data;
    } entry_t;

    localparam logic [47:0] PKT_READY = 48'h1f_1f1f_1f1f_99;
    localparam logic [47:0] PKT_ACK   = 48'h2d_2d2d_2d2d_66;
    localparam logic [47:0] PKT_NAK   = 48'ha5_a5a5_a5a5_12;
    localparam logic [7:0]  DATA_HDR  = 8'h3c;
    localparam logic [5:0]  LAST_BIT  = 6'd39;

    state_e      state, state_nxt;
    logic [47:0] pkt_q;
    pkt_type_e   type_q;
    pkt_type_e   cls;
    logic [7:0]  crc_q, crc_nxt;
    logic [5:0]  bit_cnt;
    logic        crc_fb;

    logic        accept, push, pop, bad_inc, is_bad;
    pkt_type_e   push_type;
    logic [31:0] push_data;

    entry_t [1:0] fifo_mem;
    logic         wr_ptr, rd_ptr;
    logic [1:0]   count;
    logic [15:0]  bad_cnt_q;
    entry_t       head;

    always_comb begin
        cls = T_UNKNOWN;
        if (bus.error_DEC)                  cls = T_DEC_ERR;
        else if (bus.data_DEC == PKT_READY) cls = T_READY;
        else if (bus.data_DEC == PKT_ACK)   cls = T_ACK;
        else if (bus.data_DEC == PKT_NAK)   cls = T_NAK;
        else if (bus.data_DEC[47:40] == DATA_HDR) cls = T_DATA_OK;
    end

    // Bit-serial CRC-8 (poly 0x07), MSB first over bits [47:8].
    always_comb begin
        crc_fb  = crc_q[7] ^ pkt_q[6'd47 - bit_cnt];
        crc_nxt = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
    end

    always_comb begin
        push_type = type_q;
        if (type_q == T_DATA_OK)
            push_type = (crc_q == pkt_q[7:0]) ? T_DATA_OK : T_DATA_BAD;
        is_bad    = (push_type == T_DATA_BAD) || (push_type == T_UNKNOWN) ||
                    (push_type == T_DEC_ERR);
        push_data = ((push_type == T_DATA_OK) || (push_type == T_DATA_BAD)) ?
                    pkt_q[39:8] : 32'h0;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (cls == T_DATA_OK) ? CALC : PUSH;
            CALC: if (bit_cnt == LAST_BIT) state_nxt = PUSH;
            PUSH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs; read_DEC is gated by rst_n so it stays low while reset is held
    always_comb begin
        accept  = rst_n && (state == IDLE) && bus.avail_DEC && (count < 2'd2);
        bad_inc = (state == PUSH) && is_bad;
`ifdef PKT_CHECK_DROP_BAD_EN
        push    = (state == PUSH) && !is_bad;
`else
        push    = (state == PUSH);
`endif
    end

    assign bus.read_DEC = accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q   <= '0;
            type_q  <= T_DATA_OK;
            crc_q   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            pkt_q   <= bus.data_DEC[47:0];
            type_q  <= cls;
            crc_q   <= '0;
            bit_cnt <= '0;
        end else if (state == CALC) begin
            crc_q   <= crc_nxt;
            bit_cnt <= (bit_cnt == LAST_BIT) ? 6'd0 : bit_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bad_cnt_q <= '0;
        else if (bad_inc && (bad_cnt_q != 16'hFFFF))
            bad_cnt_q <= bad_cnt_q + 16'd1;
    end

    assign pop = bus.pkt_read && (count != 2'd0);

    // Capture only admits a packet while count<2, so push never meets a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{ptype: push_type, data: push_data};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head          = fifo_mem[rd_ptr];
    assign bus.pkt_valid = (count != 2'd0);
    assign bus.pkt_type  = bus.pkt_valid ? head.ptype : 3'd0;
    assign bus.pkt_data  = bus.pkt_valid ? head.data : 32'h0;
    assign bus.bad_count = bad_cnt_q;

endmodule
